// File: rtl/sram_arbiter.sv
// sram_arbiter
// ----------------------------------------------------------------------------
// Shares one single-port byte SRAM bank between two requesters, A and B.
// An accepted request is latched in an IDLE cycle and executed in the next
// cycle (WRITE or READ), so the bank sees at most one access every two cycles.
// Read data is captured at the end of the READ cycle and returned one cycle
// later with a one-cycle rvalid pulse.
//
// Handshake: a requester raises xValid with xWrite/xAddr/xWData and holds
// them stable up to and including the cycle in which xGrant is high. On the
// edge closing that cycle the request is consumed; a request still valid in
// the following IDLE cycle is a new request.
//
// Build option:
//   SRAM_ARB_FIXED_PRI_EN  defined   -> A always wins a tie (no lastOwner)
//                          undefined -> round-robin on ties, A wins the first
//
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   aValid/aWrite/aAddr/aWData   requester A request
//   aGrant                       A's request is on the SRAM this cycle
//   aRValid/aRData               A's read data return (aRData holds)
//   b*                           same set for requester B
//   sramAddr/sramInData          SRAM address / write data (hold in IDLE)
//   sramWriteEnable              SRAM write strobe
//   sramOutputEnable             SRAM read strobe
//   sramOutData                  SRAM read data
//   dbgState                     current state encoding, for observation
// ----------------------------------------------------------------------------
module sram_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              aValid,
    input  logic              aWrite,
    input  logic [ADDR_W-1:0] aAddr,
    input  logic [DATA_W-1:0] aWData,
    output logic              aGrant,
    output logic              aRValid,
    output logic [DATA_W-1:0] aRData,
    input  logic              bValid,
    input  logic              bWrite,
    input  logic [ADDR_W-1:0] bAddr,
    input  logic [DATA_W-1:0] bWData,
    output logic              bGrant,
    output logic              bRValid,
    output logic [DATA_W-1:0] bRData,
    output logic [ADDR_W-1:0] sramAddr,
    output logic [DATA_W-1:0] sramInData,
    output logic              sramWriteEnable,
    output logic              sramOutputEnable,
    input  logic [DATA_W-1:0] sramOutData,
    output logic [1:0]        dbgState
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                owner_q, owner_d;    // 0 = A, 1 = B
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                aRValid_q, bRValid_q;
    logic [DATA_W-1:0]   aRData_q, bRData_q;
    logic                winner;              // 0 = A, 1 = B
    logic                busy;

`ifndef SRAM_ARB_FIXED_PRI_EN
    logic                lastOwner_q;
`endif

    // Winner selection. Only meaningful when at least one valid is high.
    always_comb begin
        winner = 1'b0;
`ifdef SRAM_ARB_FIXED_PRI_EN
        winner = !aValid;
`else
        if (aValid && bValid) begin
            winner = !lastOwner_q;
        end else begin
            winner = !aValid;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (aValid || bValid) begin
                    owner_d = winner;
                    if (winner) begin
                        addr_d  = bAddr;
                        wdata_d = bWData;
                        state_d = bWrite ? WRITE : READ;
                    end else begin
                        addr_d  = aAddr;
                        wdata_d = aWData;
                        state_d = aWrite ? WRITE : READ;
                    end
                end
            end
            WRITE:   state_d = IDLE;
            READ:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes and grants come straight from registers only.
    assign busy             = (state_q == WRITE) || (state_q == READ);
    assign sramWriteEnable  = (state_q == WRITE);
    assign sramOutputEnable = (state_q == READ);
    assign aGrant           = busy && !owner_q;
    assign bGrant           = busy && owner_q;
    assign sramAddr         = addr_q;
    assign sramInData       = wdata_q;
    assign aRValid          = aRValid_q;
    assign bRValid          = bRValid_q;
    assign aRData           = aRData_q;
    assign bRData           = bRData_q;
    assign dbgState         = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            aRValid_q <= 1'b0;
            bRValid_q <= 1'b0;
            aRData_q  <= '0;
            bRData_q  <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            // A reset on the edge closing READ suppresses the return.
            aRValid_q <= (state_q == READ) && !owner_q;
            bRValid_q <= (state_q == READ) && owner_q;
            if ((state_q == READ) && !owner_q) begin
                aRData_q <= sramOutData;
            end
            if ((state_q == READ) && owner_q) begin
                bRData_q <= sramOutData;
            end
        end
    end

`ifndef SRAM_ARB_FIXED_PRI_EN
    // Resets to B so that A wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            lastOwner_q <= 1'b1;
        end else if (busy) begin
            lastOwner_q <= owner_q;
        end
    end
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios plus randomized two-requester
// traffic checked against a transaction-level reference model.
module tb_sram_arbiter;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          aValid, aWrite, bValid, bWrite;
    logic [AW-1:0] aAddr, bAddr;
    logic [DW-1:0] aWData, bWData;
    logic          aGrant, aRValid, bGrant, bRValid;
    logic [DW-1:0] aRData, bRData;
    logic [AW-1:0] sramAddr;
    logic [DW-1:0] sramInData, sramOutData;
    logic          sramWriteEnable, sramOutputEnable;
    logic [1:0]    dbgState;

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- SRAM array model ----------------
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (sramWriteEnable) mem[sramAddr] <= sramInData;
    end
    assign sramOutData = sramOutputEnable ? mem[sramAddr] : '0;

    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .aValid(aValid), .aWrite(aWrite), .aAddr(aAddr), .aWData(aWData),
        .aGrant(aGrant), .aRValid(aRValid), .aRData(aRData),
        .bValid(bValid), .bWrite(bWrite), .bAddr(bAddr), .bWData(bWData),
        .bGrant(bGrant), .bRValid(bRValid), .bRData(bRData),
        .sramAddr(sramAddr), .sramInData(sramInData),
        .sramWriteEnable(sramWriteEnable), .sramOutputEnable(sramOutputEnable),
        .sramOutData(sramOutData), .dbgState(dbgState)
    );

    // ---------------- driver tasks ----------------
    task automatic drive(input bit who, input logic v, input logic w,
                         input logic [AW-1:0] ad, input logic [DW-1:0] wd);
        if (!who) begin
            aValid = v; aWrite = w; aAddr = ad; aWData = wd;
        end else begin
            bValid = v; bWrite = w; bAddr = ad; bWData = wd;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 0, 0, '0, '0);
        drive(1, 0, 0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // One complete request from one requester; returns what was observed.
    task automatic xfer(input bit who, input logic wr, input logic [AW-1:0] ad,
                        input logic [DW-1:0] wd, output int lat,
                        output logic [AW-1:0] s_addr, output logic [DW-1:0] s_wd,
                        output logic s_we, output logic s_oe, output logic rv,
                        output logic oe_after, output logic [DW-1:0] rd);
        @(posedge clk); #1;
        drive(who, 1, wr, ad, wd);
        @(negedge clk);
        lat = 99; s_addr = '0; s_wd = '0; s_we = 1'b0; s_oe = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if ((who ? bGrant : aGrant) === 1'b1) begin
                lat = i; s_addr = sramAddr; s_wd = sramInData;
                s_we = sramWriteEnable; s_oe = sramOutputEnable;
                break;
            end
        end
        @(posedge clk); #1;
        drive(who, 0, 0, '0, '0);
        @(negedge clk);
        rv = who ? bRValid : aRValid;
        rd = who ? bRData : aRData;
        oe_after = sramOutputEnable;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_cmp++;
        if ({aGrant, bGrant, aRValid, bRValid, sramWriteEnable, sramOutputEnable} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_strobes: got %b expected 000000",
                     {aGrant, bGrant, aRValid, bRValid, sramWriteEnable, sramOutputEnable});
        end
        n_cmp++;
        if (sramAddr !== '0) begin n_err++; $display("FAIL reset_addr: got %h expected 0", sramAddr); end
        n_cmp++;
        if (sramInData !== '0) begin n_err++; $display("FAIL reset_indata: got %h expected 0", sramInData); end
        n_cmp++;
        if (aRData !== '0) begin n_err++; $display("FAIL reset_ardata: got %h expected 0", aRData); end
        n_cmp++;
        if (bRData !== '0) begin n_err++; $display("FAIL reset_brdata: got %h expected 0", bRData); end
    endtask

    task automatic test_write_read();
        int lat; logic [AW-1:0] sa; logic [DW-1:0] sw, rd; logic we, oe, rv, oea;
        xfer(0, 1, 4'd3, 8'h5A, lat, sa, sw, we, oe, rv, oea, rd);
        n_cmp++;
        if (lat !== 1) begin n_err++; $display("FAIL wr_latency: got %0d expected 1", lat); end
        n_cmp++;
        if ({we, oe} !== 2'b10) begin n_err++; $display("FAIL wr_strobes: got we/oe %b expected 10", {we, oe}); end
        n_cmp++;
        if (sa !== 4'd3 || sw !== 8'h5A) begin
            n_err++; $display("FAIL wr_bus: got addr %h data %h expected 3 5a", sa, sw);
        end
        n_cmp++;
        if (rv !== 1'b0) begin n_err++; $display("FAIL wr_no_rvalid: got %b expected 0", rv); end
        xfer(0, 0, 4'd3, 8'h00, lat, sa, sw, we, oe, rv, oea, rd);
        n_cmp++;
        if (lat !== 1 || {we, oe} !== 2'b01 || sa !== 4'd3) begin
            n_err++; $display("FAIL rd_grant: got lat %0d we/oe %b addr %h expected 1 01 3", lat, {we, oe}, sa);
        end
        n_cmp++;
        if (rv !== 1'b1 || rd !== 8'h5A) begin
            n_err++; $display("FAIL rd_data: got rvalid %b data %h expected 1 5a", rv, rd);
        end
        n_cmp++;
        if (oea !== 1'b0) begin n_err++; $display("FAIL rd_oe_one_cycle: got %b expected 0", oea); end
    endtask

    // Both requesters valid continuously: A writes, B reads.
    task automatic test_contention();
        int got_q[$];
        int exp_order[];
        bit pa, pb, pg;
        int a_left;
`ifdef SRAM_ARB_FIXED_PRI_EN
        exp_order = '{0, 0, 0, 1};
        a_left = 3;
`else
        exp_order = '{0, 1, 0, 1, 0, 1};
        a_left = 1000;
`endif
        do_reset();
        pa = 0; pb = 0; pg = 0;
        drive(0, 1, 1, 4'd1, 8'h10);
        drive(1, 1, 0, 4'd1, 8'h00);
        a_left--;
        for (int cyc = 0; cyc < 60 && got_q.size() < exp_order.size(); cyc++) begin
            @(posedge clk); #1;
            if (pa) begin
                if (a_left > 0) begin
                    drive(0, 1, 1, 4'($urandom_range(0, 15)), 8'($urandom));
                    a_left--;
                end else begin
                    drive(0, 0, 0, '0, '0);
                end
            end
            if (pb) drive(1, 1, 0, 4'($urandom_range(0, 15)), '0);
            @(negedge clk);
            n_cmp++;
            if (sramWriteEnable && sramOutputEnable) begin
                n_err++; $display("FAIL cont_we_oe_excl: got both 1 expected not both");
            end
            if (aGrant || bGrant) begin
                n_cmp++;
                if (pg) begin n_err++; $display("FAIL cont_grant_gap: got grants in consecutive cycles expected a gap"); end
                got_q.push_back(bGrant ? 1 : 0);
            end
            pg = aGrant || bGrant;
            pa = aGrant;
            pb = bGrant;
        end
        drive(0, 0, 0, '0, '0);
        drive(1, 0, 0, '0, '0);
        n_cmp++;
        if (got_q.size() != exp_order.size()) begin
            n_err++; $display("FAIL cont_grant_count: got %0d expected %0d", got_q.size(), exp_order.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_order.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_order[i]) begin
                n_err++; $display("FAIL cont_order[%0d]: got %0d expected %0d (0=A 1=B)", i, got_q[i], exp_order[i]);
            end
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_same_addr();
        bit seen_bg, seen_rv;
        logic [DW-1:0] rd;
        do_reset();
        @(posedge clk); #1;
        drive(0, 1, 1, 4'd7, 8'hC3);
        drive(1, 1, 0, 4'd7, 8'h00);
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if ({aGrant, bGrant, sramWriteEnable} !== 3'b101 || sramAddr !== 4'd7) begin
            n_err++; $display("FAIL same_addr_first: got aG/bG/we %b addr %h expected 101 7",
                              {aGrant, bGrant, sramWriteEnable}, sramAddr);
        end
        seen_bg = 0; seen_rv = 0; rd = '0;
        @(posedge clk); #1;
        drive(0, 0, 0, '0, '0);
        for (int i = 0; i < 8 && !seen_rv; i++) begin
            @(negedge clk);
            if (bGrant) seen_bg = 1;
            if (bRValid) begin seen_rv = 1; rd = bRData; end
            @(posedge clk); #1;
            if (seen_bg) drive(1, 0, 0, '0, '0);
        end
        n_cmp++;
        if (!seen_rv || rd !== 8'hC3) begin
            n_err++; $display("FAIL same_addr_raw: got rvalid %b data %h expected 1 c3", seen_rv, rd);
        end
    endtask

    task automatic test_reset_mid_read();
        int lat; logic [AW-1:0] sa; logic [DW-1:0] sw, rd; logic we, oe, rv, oea;
        bit seen_rv;
        do_reset();
        xfer(0, 1, 4'd5, 8'h77, lat, sa, sw, we, oe, rv, oea, rd);
        @(posedge clk); #1;
        drive(0, 1, 0, 4'd5, 8'h00);
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if ({aGrant, sramOutputEnable} !== 2'b11) begin
            n_err++; $display("FAIL midrd_in_read: got aG/oe %b expected 11", {aGrant, sramOutputEnable});
        end
        reset = 1'b1;
        drive(0, 0, 0, '0, '0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({aGrant, aRValid, sramWriteEnable, sramOutputEnable} !== 4'b0) begin
            n_err++; $display("FAIL midrd_after_reset: got aG/aRV/we/oe %b expected 0000",
                              {aGrant, aRValid, sramWriteEnable, sramOutputEnable});
        end
        seen_rv = aRValid;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (aRValid) seen_rv = 1;
        end
        n_cmp++;
        if (seen_rv) begin n_err++; $display("FAIL midrd_no_rvalid: got rvalid 1 expected none"); end
        xfer(0, 0, 4'd5, 8'h00, lat, sa, sw, we, oe, rv, oea, rd);
        n_cmp++;
        if (lat !== 1 || rv !== 1'b1 || rd !== 8'h77) begin
            n_err++; $display("FAIL midrd_reread: got lat %0d rvalid %b data %h expected 1 1 77", lat, rv, rd);
        end
    endtask

    task automatic test_boundary();
        int lat; logic [AW-1:0] sa; logic [DW-1:0] sw, rd; logic we, oe, rv, oea;
        xfer(0, 1, 4'd0, 8'h01, lat, sa, sw, we, oe, rv, oea, rd);
        n_cmp++;
        if (sa !== 4'd0 || sw !== 8'h01 || we !== 1'b1) begin
            n_err++; $display("FAIL bnd_wr0: got addr %h data %h we %b expected 0 01 1", sa, sw, we);
        end
        xfer(1, 1, 4'd15, 8'hFF, lat, sa, sw, we, oe, rv, oea, rd);
        n_cmp++;
        if (sa !== 4'd15 || sw !== 8'hFF || we !== 1'b1) begin
            n_err++; $display("FAIL bnd_wr15: got addr %h data %h we %b expected f ff 1", sa, sw, we);
        end
        xfer(0, 0, 4'd0, 8'h00, lat, sa, sw, we, oe, rv, oea, rd);
        n_cmp++;
        if (sa !== 4'd0 || rv !== 1'b1 || rd !== 8'h01) begin
            n_err++; $display("FAIL bnd_rd0: got addr %h rvalid %b data %h expected 0 1 01", sa, rv, rd);
        end
        xfer(1, 0, 4'd15, 8'h00, lat, sa, sw, we, oe, rv, oea, rd);
        n_cmp++;
        if (sa !== 4'd15 || rv !== 1'b1 || rd !== 8'hFF) begin
            n_err++; $display("FAIL bnd_rd15: got addr %h rvalid %b data %h expected f 1 ff", sa, rv, rd);
        end
    endtask

    // Randomized traffic against a transaction-level model: an access is
    // decided in an idle cycle, executed the next cycle, read data returns
    // one cycle after that; ties go to the requester not granted last.
    task automatic test_random();
        logic [DW-1:0] ref_mem [0:(1<<AW)-1];
        logic [DW-1:0] exp_q[$];
        int lat; logic [AW-1:0] sa; logic [DW-1:0] sw, rd; logic we, oe, rv, oea;
        int cur, nxt, rv_due, rv_next, last_w, done;
        logic cur_wr, nxt_wr;
        logic [AW-1:0] cur_ad, nxt_ad;
        logic [DW-1:0] cur_wd, nxt_wd, a_hold, b_hold, d;
        bit ag_prev, bg_prev;

        for (int i = 0; i < (1 << AW); i++) begin
            ref_mem[i] = 8'($urandom);
            xfer(0, 1, 4'(i), ref_mem[i], lat, sa, sw, we, oe, rv, oea, rd);
        end
        do_reset();
        cur = -1; rv_due = -1; rv_next = -1; done = 0;
        last_w = 1;
        a_hold = '0; b_hold = '0;
        ag_prev = 0; bg_prev = 0;
        for (int cyc = 0; cyc < 1500 && done < 60; cyc++) begin
            @(posedge clk); #1;
            if (ag_prev || !aValid) begin
                if ($urandom_range(0, 3) != 0)
                    drive(0, 1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom));
                else
                    drive(0, 0, 0, '0, '0);
            end
            if (bg_prev || !bValid) begin
                if ($urandom_range(0, 3) != 0)
                    drive(1, 1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom));
                else
                    drive(1, 0, 0, '0, '0);
            end
            @(negedge clk);
            n_cmp++;
            if ({aGrant, bGrant, sramWriteEnable, sramOutputEnable} !==
                {cur == 0, cur == 1, cur >= 0 && cur_wr, cur >= 0 && !cur_wr}) begin
                n_err++;
                $display("FAIL rnd_strobes cyc %0d: got aG/bG/we/oe %b expected %b", cyc,
                         {aGrant, bGrant, sramWriteEnable, sramOutputEnable},
                         {cur == 0, cur == 1, cur >= 0 && cur_wr, cur >= 0 && !cur_wr});
            end
            if (cur >= 0) begin
                n_cmp++;
                if (sramAddr !== cur_ad || (cur_wr && sramInData !== cur_wd)) begin
                    n_err++;
                    $display("FAIL rnd_bus cyc %0d: got addr %h data %h expected %h %h", cyc,
                             sramAddr, sramInData, cur_ad, cur_wd);
                end
                if (cur_wr) ref_mem[cur_ad] = cur_wd;
                else begin
                    exp_q.push_back(ref_mem[cur_ad]);
                    rv_next = cur;
                end
                done++;
            end
            n_cmp++;
            if ({aRValid, bRValid} !== {rv_due == 0, rv_due == 1}) begin
                n_err++;
                $display("FAIL rnd_rvalid cyc %0d: got aRV/bRV %b expected %b", cyc,
                         {aRValid, bRValid}, {rv_due == 0, rv_due == 1});
            end
            if (rv_due >= 0 && exp_q.size() > 0) begin
                d = exp_q.pop_front();
                if (rv_due == 0) a_hold = d; else b_hold = d;
            end
            n_cmp++;
            if (aRData !== a_hold || bRData !== b_hold) begin
                n_err++;
                $display("FAIL rnd_rdata cyc %0d: got a %h b %h expected a %h b %h", cyc,
                         aRData, bRData, a_hold, b_hold);
            end
            rv_due = rv_next;
            rv_next = -1;
            nxt = -1; nxt_wr = 0; nxt_ad = '0; nxt_wd = '0;
            if (cur < 0 && (aValid || bValid)) begin
`ifdef SRAM_ARB_FIXED_PRI_EN
                nxt = aValid ? 0 : 1;
`else
                if (aValid && bValid) nxt = (last_w == 0) ? 1 : 0;
                else nxt = aValid ? 0 : 1;
`endif
                last_w = nxt;
                nxt_wr = nxt ? bWrite : aWrite;
                nxt_ad = nxt ? bAddr : aAddr;
                nxt_wd = nxt ? bWData : aWData;
            end
            cur = nxt; cur_wr = nxt_wr; cur_ad = nxt_ad; cur_wd = nxt_wd;
            ag_prev = aGrant;
            bg_prev = bGrant;
        end
        n_cmp++;
        if (done < 60) begin n_err++; $display("FAIL rnd_progress: got %0d accesses expected 60", done); end
        @(posedge clk); #1;
        drive(0, 0, 0, '0, '0);
        drive(1, 0, 0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        reset = 1'b1;
        drive(0, 0, 0, '0, '0);
        drive(1, 0, 0, '0, '0);
        test_reset();
        test_write_read();
        test_contention();
        test_same_addr();
        test_reset_mid_read();
        test_boundary();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
